button_conditioner: RTL and testbench

- Input stage between the board push-buttons (active-low KEYs) and the game top level.
- Per button: synchronises, debounces, and emits a clean active-high level plus one-cycle press/release pulses.
- Optional per-button auto-repeat pulse train for held movement keys.
- The top-level state machine consumes the press pulses for start/restart edges and the levels for ship movement.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_debounce_ch.sv | 117 +++++++++++
 rtl/button_conditioner.sv | 39 +++
 tb/tb_button_conditioner.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button input stage.
package btn_pkg;

  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;
  localparam int BTN_D = 3;

  // Board defaults at 50 MHz: 20 ms debounce, 500 ms first repeat, 100 ms repeat period.
  localparam int DEF_N_BTN           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release pulses,
// and the auto-repeat FSM when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_param
    $error("btn_debounce_ch: timing parameters must be at least 2");
  end

  logic             sync_a;
  logic             sync_s;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // stable is active-low like the raw key; flip fires on the last cycle of a full hold.
  assign flip    = (sync_s != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign pressed = ~stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a        <= 1'b1;
      sync_s        <= 1'b1;
      stable        <= 1'b1;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_a        <= btn_n;
      sync_s        <= sync_a;
      press_pulse   <= flip && stable;
      release_pulse <= flip && !stable;
      if (sync_s == stable || flip) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      if (flip) stable <= ~stable;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W  = $clog2(RPT_MAX);

  rpt_state_e        rpt_state;
  rpt_state_e        rpt_state_nx;
  logic [RCNT_W-1:0] rcnt;
  logic [RCNT_W-1:0] rcnt_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_state <= IDLE;
      rcnt      <= '0;
    end else begin
      rpt_state <= rpt_state_nx;
      rcnt      <= rcnt_nx;
    end
  end

  // Release wins over a repeat due in the same cycle.
  always_comb begin
    rpt_state_nx = rpt_state;
    rcnt_nx      = rcnt;
    repeat_pulse = 1'b0;
    if (!pressed) begin
      rpt_state_nx = IDLE;
      rcnt_nx      = '0;
    end else begin
      case (rpt_state)
        IDLE: begin
          if (press_pulse) begin
            rpt_state_nx = DELAY;
            rcnt_nx      = '0;
          end
        end
        DELAY: begin
          if (rcnt == RCNT_W'(REPEAT_DELAY - 1)) begin
            repeat_pulse = 1'b1;
            rcnt_nx      = '0;
            rpt_state_nx = REPEAT;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rcnt == RCNT_W'(REPEAT_RATE - 1)) begin
            repeat_pulse = 1'b1;
            rcnt_nx      = '0;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
        end
        default: begin
          rpt_state_nx = IDLE;
          rcnt_nx      = '0;
        end
      endcase
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN active-low board keys into clean levels and edge pulses.
// Define BTN_AUTOREPEAT_EN to build the per-channel auto-repeat pulse train.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .btn_n         (btn_n[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing (debounce 4, delay 10, rate 3).
// Repeat expectations apply only when BTN_AUTOREPEAT_EN is defined; otherwise repeat_pulse must stay 0.
module tb_button_conditioner;

  localparam int N_BTN = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] pressed;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] repeat_pulse;
  logic             any_press;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_n         (btn_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_press     (any_press)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected packed as {pressed, press_pulse, release_pulse, repeat_pulse, any_press}.
  task automatic check(input string tag, input logic [3:0] e_pr, input logic [3:0] e_pp,
                       input logic [3:0] e_rp, input logic [3:0] e_rep);
    logic [16:0] obs;
    logic [16:0] exp;
    logic [3:0]  rep_e;
    rep_e = RPT_ON ? e_rep : 4'h0;
    exp   = {e_pr, e_pp, e_rp, rep_e, |e_pp};
    obs   = {pressed, press_pulse, release_pulse, repeat_pulse, any_press};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_n = 4'hF;
    cyc();
    cyc();
    check("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    for (int o = 1; o <= 3; o++) begin
      cyc();
      check($sformatf("idle_o%0d", o), 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Clean press on A, hold 30 cycles past acceptance (offset 6), then release;
    // release acceptance lands on offset 37, where a repeat would otherwise fall.
    btn_n[0] = 1'b0;
    for (int o = 1; o <= 42; o++) begin
      cyc();
      check($sformatf("hold_o%0d", o),
            (o >= 6 && o <= 36) ? 4'h1 : 4'h0,
            (o == 6)  ? 4'h1 : 4'h0,
            (o == 37) ? 4'h1 : 4'h0,
            (o >= 16 && o <= 36 && (o - 16) % 3 == 0) ? 4'h1 : 4'h0);
      if (o == 31) btn_n[0] = 1'b1;
    end

    // Glitch on B: 3 low cycles rejected.
    btn_n[1] = 1'b0;
    for (int o = 1; o <= 12; o++) begin
      cyc();
      check($sformatf("glitch3_o%0d", o), 4'h0, 4'h0, 4'h0, 4'h0);
      if (o == 3) btn_n[1] = 1'b1;
    end

    // 4 low cycles on B: accepted at 6, then the return high is accepted at 10.
    btn_n[1] = 1'b0;
    for (int o = 1; o <= 14; o++) begin
      cyc();
      check($sformatf("glitch4_o%0d", o),
            (o >= 6 && o <= 9) ? 4'h2 : 4'h0,
            (o == 6)  ? 4'h2 : 4'h0,
            (o == 10) ? 4'h2 : 4'h0,
            4'h0);
      if (o == 4) btn_n[1] = 1'b1;
    end

    // Bounce on C: 0,1,0,1 then settle low at offset 4 -> one press at 10; release at 18.
    btn_n[2] = 1'b0;
    for (int o = 1; o <= 20; o++) begin
      cyc();
      check($sformatf("bounce_o%0d", o),
            (o >= 10 && o <= 17) ? 4'h4 : 4'h0,
            (o == 10) ? 4'h4 : 4'h0,
            (o == 18) ? 4'h4 : 4'h0,
            4'h0);
      case (o)
        1, 3:    btn_n[2] = 1'b1;
        2, 4:    btn_n[2] = 1'b0;
        12:      btn_n[2] = 1'b1;
        default: ;
      endcase
    end

    // All four together, then a one-cycle reset mid-hold (sampled at offset 8);
    // the still-held keys are re-accepted 6 cycles later, then released.
    btn_n = 4'h0;
    for (int o = 1; o <= 22; o++) begin
      cyc();
      check($sformatf("simul_o%0d", o),
            ((o >= 6 && o <= 7) || (o >= 14 && o <= 20)) ? 4'hF : 4'h0,
            (o == 6 || o == 14) ? 4'hF : 4'h0,
            (o == 21) ? 4'hF : 4'h0,
            4'h0);
      if (o == 7)  reset = 1'b1;
      if (o == 8)  reset = 1'b0;
      if (o == 15) btn_n = 4'hF;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
